// File: rtl/pyrite_bpi_apb_seq_if.sv
// APB bus bundle used by the Pyrite BPI sequencer: master drives the request,
// slave answers with prdata/pready/pslverr.
`timescale 1ns/1ps
interface taxi_apb_if #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned STRB_W   = DATA_W / 8,
    parameter int unsigned PAUSER_W = 1,
    parameter int unsigned PWUSER_W = 1
);
    logic [ADDR_W-1:0]   paddr;
    logic [2:0]          pprot;
    logic                psel;
    logic                penable;
    logic                pwrite;
    logic [DATA_W-1:0]   pwdata;
    logic [STRB_W-1:0]   pstrb;
    logic [PAUSER_W-1:0] pauser;
    logic [PWUSER_W-1:0] pwuser;
    logic [DATA_W-1:0]   prdata;
    logic                pready;
    logic                pslverr;

    modport mst (
        output paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pauser, pwuser,
        input  prdata, pready, pslverr
    );

    modport slv (
        input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pauser, pwuser,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/pyrite_bpi_apb_seq.sv
// Turns one flash read/write command into the Pyrite BPI register sequence on APB.
// Optional ACCESS watchdog: define PYRITE_BPI_SEQ_TIMEOUT_EN.
`timescale 1ns/1ps
module pyrite_bpi_apb_seq #(
    parameter logic [13:0] REG_BASE = 14'h0000,
    parameter int unsigned FLASH_AW = 26,
    parameter int unsigned FLASH_DW = 16,
    parameter int unsigned WAIT_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [FLASH_AW-1:0] cmd_addr,
    input  logic [FLASH_DW-1:0] cmd_data,
    input  logic [WAIT_W-1:0]   cfg_wait,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [FLASH_DW-1:0] rsp_data,
    output logic                rsp_err,
    taxi_apb_if.mst             m_apb
);
    localparam int unsigned AW = 14;
    localparam int unsigned DW = 32;
    localparam logic [AW-1:0] A_CTRL = AW'(REG_BASE + 14'h0050);
    localparam logic [AW-1:0] A_ADDR = AW'(REG_BASE + 14'h0054);
    localparam logic [AW-1:0] A_DATA = AW'(REG_BASE + 14'h0058);
    localparam logic [DW-1:0] CTRL_DESEL = 32'h0001_000F;

    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_WAIT, ST_RESP} state_t;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } xfer_t;

    // Register transfer issued at a given step of a read or write sequence.
    function automatic xfer_t step_xfer(input logic wr, input logic [2:0] step,
                                        input logic [FLASH_AW-1:0] a,
                                        input logic [FLASH_DW-1:0] d);
        xfer_t x;
        x.wr    = 1'b1;
        x.addr  = A_CTRL;
        x.wdata = CTRL_DESEL;
        if (step == 3'd0) begin
            x.addr  = A_ADDR;
            x.wdata = DW'(a);
        end else if (wr) begin
            case (step)
                3'd1: begin
                    x.addr  = A_DATA;
                    x.wdata = DW'(d);
                end
                3'd2: x.wdata = 32'h0001_0106;
                3'd3: x.wdata = 32'h0001_010A;
                3'd4: x.wdata = 32'h0001_010E;
                default: ;
            endcase
        end else begin
            case (step)
                3'd1: x.wdata = 32'h0001_0006;
                3'd2: x.wdata = 32'h0001_000C;
                3'd3: begin
                    x.wr    = 1'b0;
                    x.addr  = A_DATA;
                    x.wdata = '0;
                end
                default: ;
            endcase
        end
        return x;
    endfunction

    state_t                state_q, state_d;
    logic [2:0]            step_q, step_d;
    logic                  write_q, write_d;
    logic [FLASH_AW-1:0]   addr_q, addr_d;
    logic [FLASH_DW-1:0]   data_q, data_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic [WAIT_W-1:0]     wcnt_q, wcnt_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [AW-1:0]         paddr_q, paddr_d;
    logic [DW-1:0]         pwdata_q, pwdata_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [FLASH_DW-1:0]   rsp_data_q, rsp_data_d;
    logic                  rsp_err_q, rsp_err_d;
`ifdef PYRITE_BPI_SEQ_TIMEOUT_EN
    logic [7:0]            tmo_q, tmo_d;
`endif

    logic                  idle_c;
    logic [2:0]            nstep_c;
    logic [2:0]            last_step_c;
    logic [2:0]            wait_step_c;
    xfer_t                 nx_c;
    logic                  launch;
    logic                  unused_prdata_c;

    // Next transfer comes from the live command in IDLE, from the latched one afterwards.
    assign idle_c      = (state_q == ST_IDLE);
    assign nstep_c     = idle_c ? 3'd0 : step_q + 3'd1;
    assign nx_c        = idle_c ? step_xfer(cmd_write, nstep_c, cmd_addr, cmd_data)
                                : step_xfer(write_q, nstep_c, addr_q, data_q);
    assign last_step_c = write_q ? 3'd5 : 3'd4;
    assign wait_step_c = write_q ? 3'd3 : 3'd2;

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        write_d     = write_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wait_d      = wait_q;
        wcnt_d      = wcnt_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
`ifdef PYRITE_BPI_SEQ_TIMEOUT_EN
        tmo_d       = tmo_q;
`endif
        launch      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    write_d     = cmd_write;
                    addr_d      = cmd_addr;
                    data_d      = cmd_data;
                    wait_d      = cfg_wait;
                    rsp_err_d   = 1'b0;
                    rsp_data_d  = '0;
                    launch      = 1'b1;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (m_apb.pready) begin
                    if (m_apb.pslverr) rsp_err_d = 1'b1;
                    if (!pwrite_q) rsp_data_d = m_apb.prdata[FLASH_DW-1:0];
                    if (step_q == last_step_c) begin
                        psel_d      = 1'b0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else if (step_q == wait_step_c && wait_q != '0) begin
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                        wcnt_d    = wait_q;
                        state_d   = ST_WAIT;
                    end else begin
                        launch = 1'b1;
                    end
                end
`ifdef PYRITE_BPI_SEQ_TIMEOUT_EN
                else if (tmo_q == 8'hFF) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
`endif
            end
            ST_WAIT: begin
                if (wcnt_q == WAIT_W'(1)) launch = 1'b1;
                else wcnt_d = wcnt_q - WAIT_W'(1);
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Start the SETUP phase of the next transfer with all request fields frozen.
        if (launch) begin
            step_d    = nstep_c;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = nx_c.wr;
            paddr_d   = nx_c.addr;
            pwdata_d  = nx_c.wdata;
            state_d   = ST_SETUP;
`ifdef PYRITE_BPI_SEQ_TIMEOUT_EN
            tmo_d     = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            wait_q      <= '0;
            wcnt_q      <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
`ifdef PYRITE_BPI_SEQ_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wait_q      <= wait_d;
            wcnt_q      <= wcnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
`ifdef PYRITE_BPI_SEQ_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

    assign unused_prdata_c = ^m_apb.prdata;

    assign cmd_ready      = cmd_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_err        = rsp_err_q;
    assign m_apb.psel     = psel_q;
    assign m_apb.penable  = penable_q;
    assign m_apb.pwrite   = pwrite_q;
    assign m_apb.paddr    = paddr_q;
    assign m_apb.pwdata   = pwdata_q;
    assign m_apb.pstrb    = pwrite_q ? 4'hF : 4'h0;
    assign m_apb.pprot    = 3'b000;
    assign m_apb.pauser   = '0;
    assign m_apb.pwuser   = '0;
endmodule

// File: tb/tb_pyrite_bpi_apb_seq.sv
// Bench for pyrite_bpi_apb_seq: APB responder/monitor with a transfer scoreboard,
// a table of commands, and hand-written reset and timeout sequences.
`timescale 1ns/1ps
module tb_pyrite_bpi_apb_seq;
    localparam logic [13:0] BASE = 14'h0100;
    localparam logic [13:0] A_CTRL = BASE + 14'h0050;
    localparam logic [13:0] A_ADDR = BASE + 14'h0054;
    localparam logic [13:0] A_DATA = BASE + 14'h0058;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [25:0] cmd_addr = '0;
    logic [15:0] cmd_data = '0;
    logic [7:0]  cfg_wait = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        rsp_err;

    taxi_apb_if #(.DATA_W(32), .ADDR_W(14)) apb ();

    pyrite_bpi_apb_seq #(.REG_BASE(BASE), .FLASH_AW(26), .FLASH_DW(16), .WAIT_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cfg_wait(cfg_wait),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .m_apb(apb)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic wr; logic [13:0] addr; logic [31:0] wdata; } xfer_t;
    typedef struct { logic [15:0] data; logic err; int lat; } rsp_t;
    typedef struct {
        logic wr; logic [25:0] addr; logic [15:0] data; logic [7:0] wt;
        int ws; int err_at; logic [15:0] rd_reg;
        logic [15:0] exp_data; logic exp_err; int exp_lat;
    } vec_t;

    xfer_t xq[$];
    rsp_t  rq[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected register sequence for one command, straight from the flash protocol.
    task automatic push_xfers(input logic wr, input logic [25:0] a, input logic [15:0] d);
        xq.push_back('{1'b1, A_ADDR, 32'(a)});
        if (wr) begin
            xq.push_back('{1'b1, A_DATA, 32'(d)});
            xq.push_back('{1'b1, A_CTRL, 32'h0001_0106});
            xq.push_back('{1'b1, A_CTRL, 32'h0001_010A});
            xq.push_back('{1'b1, A_CTRL, 32'h0001_010E});
        end else begin
            xq.push_back('{1'b1, A_CTRL, 32'h0001_0006});
            xq.push_back('{1'b1, A_CTRL, 32'h0001_000C});
            xq.push_back('{1'b0, A_DATA, 32'h0});
        end
        xq.push_back('{1'b1, A_CTRL, 32'h0001_000F});
    endtask

    // Responder and monitor: answers at negedge, checks SETUP/ACCESS stability and order.
    int ws_cfg = 0;
    int err_at = -1;
    int xfer_idx = 0;
    int acc_cnt = 0;
    logic [15:0] data_reg = '0;
    logic        s_wr;
    logic [13:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_strb;

    initial begin
        apb.pready = 1'b0;
        apb.pslverr = 1'b0;
        apb.prdata = '0;
    end

    always @(negedge clk) begin
        xfer_t e;
        apb.pready  = 1'b0;
        apb.pslverr = 1'b0;
        apb.prdata  = '0;
        if (apb.psel && !apb.penable) begin
            s_wr = apb.pwrite; s_addr = apb.paddr; s_wdata = apb.pwdata; s_strb = apb.pstrb;
            acc_cnt = 0;
        end else if (apb.psel && apb.penable) begin
            chk("access_stable", {apb.pwrite, apb.paddr, apb.pwdata, apb.pstrb},
                {s_wr, s_addr, s_wdata, s_strb});
            if (acc_cnt >= ws_cfg) begin
                apb.pready  = 1'b1;
                apb.pslverr = (xfer_idx == err_at);
                apb.prdata  = {16'hDEAD, data_reg};
                chk("xfer_expected", 64'(xq.size() != 0), 1);
                if (xq.size() != 0) begin
                    e = xq.pop_front();
                    chk("xfer_pwrite", apb.pwrite, e.wr);
                    chk("xfer_paddr", apb.paddr, e.addr);
                    if (e.wr) chk("xfer_pwdata", apb.pwdata, e.wdata);
                    chk("xfer_pstrb", apb.pstrb, e.wr ? 4'hF : 4'h0);
                    chk("xfer_pprot", apb.pprot, 3'b000);
                end
                xfer_idx++;
            end
            acc_cnt++;
        end
    end

    task automatic run_cmd(input vec_t v, input bit hold_busy);
        rsp_t e;
        int t;
        int acc;
        ws_cfg = v.ws; err_at = v.err_at; data_reg = v.rd_reg; xfer_idx = 0;
        push_xfers(v.wr, v.addr, v.data);
        rq.push_back('{data: v.exp_data, err: v.exp_err, lat: v.exp_lat});
        @(negedge clk);
        cmd_write = v.wr; cmd_addr = v.addr; cmd_data = v.data; cfg_wait = v.wt;
        cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
        chk("cmd_ready_wait", cmd_ready, 1'b1);
        @(negedge clk);
        acc = cyc;
        if (hold_busy) begin
            cmd_write = ~v.wr; cmd_addr = ~v.addr; cmd_data = ~v.data; cfg_wait = 8'd7;
            for (int k = 0; k < 4; k++) begin
                chk("cmd_ready_busy", cmd_ready, 1'b0);
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        t = 0;
        while (!rsp_valid && t < 2000) begin @(negedge clk); t++; end
        chk("rsp_valid_seen", rsp_valid, 1'b1);
        e = rq.pop_front();
        chk("rsp_latency", 64'(cyc - acc + 1), 64'(e.lat));
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", rsp_err, e.err);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("rsp_hold_valid", rsp_valid, 1'b1);
            chk("rsp_hold_data", {rsp_data, rsp_err}, {e.data, e.err});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", rsp_valid, 1'b0);
        chk("cmd_ready_after_rsp", cmd_ready, 1'b1);
        chk("xfers_left", 64'(xq.size()), 0);
        xq.delete();
    endtask

    vec_t vecs[6];

    initial begin
        int t;
        vecs[0] = '{1'b0, 26'h0123456, 16'h0000, 8'd4, 0, -1, 16'hBEEF, 16'hBEEF, 1'b0, 15};
        vecs[1] = '{1'b1, 26'h2000000, 16'h00A5, 8'd0, 0, -1, 16'h0000, 16'h0000, 1'b0, 13};
        vecs[2] = '{1'b0, 26'h3FFFFFF, 16'h0000, 8'd2, 1, -1, 16'h1234, 16'h1234, 1'b0, 18};
        vecs[3] = '{1'b1, 26'h0000001, 16'hFFFF, 8'd3, 0,  1, 16'h0000, 16'h0000, 1'b1, 16};
        vecs[4] = '{1'b0, 26'h0000000, 16'h0000, 8'd0, 2,  3, 16'h5A5A, 16'h5A5A, 1'b1, 21};
        vecs[5] = '{1'b1, 26'h1555555, 16'hC33C, 8'd1, 1, -1, 16'h0000, 16'h0000, 1'b0, 20};

        @(negedge clk);
        @(negedge clk);
        chk("rst_psel", apb.psel, 1'b0);
        chk("rst_penable", apb.penable, 1'b0);
        chk("rst_pwrite", apb.pwrite, 1'b0);
        chk("rst_paddr", apb.paddr, 14'h0);
        chk("rst_pwdata", apb.pwdata, 32'h0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_data", rsp_data, 16'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_first_edge", cmd_ready, 1'b1);

        for (int i = 0; i < 6; i++) run_cmd(vecs[i], i == 1);

        // Asynchronous reset while the third transfer sits in ACCESS.
        ws_cfg = 3; err_at = -1; xfer_idx = 0; data_reg = 16'h0;
        push_xfers(1'b0, 26'h0000155, 16'h0);
        @(negedge clk);
        cmd_write = 1'b0; cmd_addr = 26'h0000155; cfg_wait = 8'd1; cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (!(xfer_idx == 2 && apb.psel && apb.penable) && t < 200) begin
            @(negedge clk); t++;
        end
        chk("reached_step3_access", 64'(xfer_idx == 2 && apb.psel && apb.penable), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_psel", apb.psel, 1'b0);
        chk("async_rst_penable", apb.penable, 1'b0);
        chk("async_rst_paddr", apb.paddr, 14'h0);
        chk("async_rst_cmd_ready", cmd_ready, 1'b0);
        chk("async_rst_rsp_valid", rsp_valid, 1'b0);
        xq.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_midop_rst", cmd_ready, 1'b1);
        run_cmd(vecs[0], 1'b0);

`ifdef PYRITE_BPI_SEQ_TIMEOUT_EN
        begin
            int n_acc;
            ws_cfg = 1 << 30; err_at = -1; xfer_idx = 0;
            @(negedge clk);
            cmd_write = 1'b0; cmd_addr = 26'h0000042; cfg_wait = 8'd0; cmd_valid = 1'b1;
            t = 0;
            while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
            @(negedge clk);
            cmd_valid = 1'b0;
            n_acc = 0;
            t = 0;
            while (apb.psel && t < 1000) begin
                if (apb.penable) n_acc++;
                @(negedge clk); t++;
            end
            chk("timeout_access_cycles", 64'(n_acc), 256);
            chk("timeout_psel", apb.psel, 1'b0);
            chk("timeout_rsp_valid", rsp_valid, 1'b1);
            chk("timeout_rsp_err", rsp_err, 1'b1);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            chk("timeout_cmd_ready", cmd_ready, 1'b1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
        $fatal(1);
    end
endmodule
